// File: rtl/sort_wb_packer_pkg.sv
// Shared definitions for the merge-sort write-back path: DRAM request
// encodings, line/key geometry, address stepping and the packer FSM states.
package sort_wb_packer_pkg;

  localparam int DRAMW  = 512;
  localparam int KEYW   = 32;
  localparam int KPL    = DRAMW / KEYW;
  localparam int LANE_W = $clog2(KPL);

  localparam logic [31:0] ADR_STEP      = 32'd8;
  localparam logic [31:0] MEM_LAST_ADDR = 32'h07FF_FFF8;

  localparam logic [1:0] DRAM_REQ_NONE  = 2'd0;
  localparam logic [1:0] DRAM_REQ_WRITE = 2'd1;
  localparam logic [1:0] DRAM_REQ_READ  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WRITE,
    ST_DRAIN_WAIT,
    ST_FIN
  } wb_state_e;

  // Line address following adr; the DRAM region wraps back to 0.
  function automatic logic [31:0] next_line_adr(input logic [31:0] adr);
    return (adr == MEM_LAST_ADDR) ? 32'd0 : adr + ADR_STEP;
  endfunction

endpackage

// File: rtl/sort_wb_packer_wb_line_fifo.sv
// First-word-fall-through line FIFO for the write-back packer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointers and count only)
//   wr_en     : push wr_data (ignored when full)
//   rd_en     : pop the head (ignored when empty)
//   rd_data   : current head entry, valid whenever count != 0
//   count     : number of stored entries, 0..DEPTH
module wb_line_fifo #(
  parameter int W     = 512,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  always_comb begin
    do_wr    = wr_en && (count_q != FULL_CNT);
    do_rd    = rd_en && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    // push and pop together leave the occupancy unchanged
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/sort_wb_packer.sv
// Write-back packer: packs sorted 32-bit keys 16 per DRAM line, queues
// lines in a FIFO and issues fixed-size write bursts to the DRAM controller.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   START, BASE_ADR     : begin a phase at BASE_ADR (honoured only when idle)
//   IN_VALID, IN_KEY    : key stream; IN_FULL is the backpressure
//   FLUSH               : end of stream; pads and drains the last line
//   D_BUSY, D_W         : controller status / data-consume strobe
//   D_REQ, D_INITADR,
//   D_BLOCKS, D_DIN     : burst request and FWFT line data
//   DONE, ERR, LINES    : phase complete pulse, sticky error, lines written
module sort_wb_packer
  import sort_wb_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int BURST      = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [31:0]      BASE_ADR,
  input  logic             IN_VALID,
  input  logic [KEYW-1:0]  IN_KEY,
  input  logic             FLUSH,
  output logic             IN_FULL,
  input  logic             D_BUSY,
  input  logic             D_W,
  output logic [1:0]       D_REQ,
  output logic [31:0]      D_INITADR,
  output logic [31:0]      D_BLOCKS,
  output logic [DRAMW-1:0] D_DIN,
  output logic             DONE,
  output logic             ERR,
  output logic [31:0]      LINES
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BURST_CNT = CW'(BURST);

  wb_state_e         state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [DRAMW-1:0]  line_q, line_d;
  logic              flush_pend_q, flush_pend_d;
  logic [31:0]       cur_adr_q, cur_adr_d;
  logic [31:0]       lines_q, lines_d;
  logic [CW-1:0]     remain_q, remain_d;
  logic [1:0]        d_req_q, d_req_d;
  logic [31:0]       d_initadr_q, d_initadr_d;
  logic [31:0]       d_blocks_q, d_blocks_d;
  logic              err_q, err_d;

  logic              push, pop, pad_now, key_ok, in_full;
  logic [DRAMW-1:0]  push_line;
  logic [CW-1:0]     fifo_cnt;

  function automatic logic [CW-1:0] clip_blocks(input logic [CW-1:0] cnt);
    return (cnt >= BURST_CNT) ? BURST_CNT : cnt;
  endfunction

  wb_line_fifo #(
    .W     (DRAMW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (push),
    .wr_data (push_line),
    .rd_en   (pop),
    .rd_data (D_DIN),
    .count   (fifo_cnt)
  );

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    line_d       = line_q;
    flush_pend_d = flush_pend_q;
    cur_adr_d    = cur_adr_q;
    lines_d      = lines_q;
    remain_d     = remain_q;
    d_req_d      = DRAM_REQ_NONE;
    d_initadr_d  = d_initadr_q;
    d_blocks_d   = d_blocks_q;
    err_d        = err_q;
    push         = 1'b0;
    pop          = 1'b0;
    push_line    = line_q;

    in_full = (fifo_cnt == FULL_CNT);
    // A partial line left behind by FLUSH is padded and pushed before any new key.
    pad_now = flush_pend_q && (lane_q != '0);
    key_ok  = IN_VALID && !in_full && !pad_now;

    if (pad_now) begin
      if (!in_full) begin
        for (int k = 0; k < KPL; k++) begin
          if (k >= int'(lane_q)) push_line[KEYW*k +: KEYW] = '1;
        end
        push   = 1'b1;
        lane_d = '0;
      end
    end else if (key_ok) begin
      push_line[KEYW*int'(lane_q) +: KEYW] = IN_KEY;
      line_d = push_line;
      if (lane_q == LANE_W'(KPL-1)) begin
        push   = 1'b1;
        lane_d = '0;
      end else begin
        lane_d = lane_q + LANE_W'(1);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (flush_pend_q && (lane_q == '0) && (fifo_cnt == '0)) begin
          state_d = ST_FIN;
        end else if (!D_BUSY && ((fifo_cnt >= BURST_CNT) ||
                     (flush_pend_q && (lane_q == '0) && (fifo_cnt != '0)))) begin
          state_d     = ST_REQ;
          d_req_d     = DRAM_REQ_WRITE;
          d_initadr_d = cur_adr_q;
          d_blocks_d  = 32'(clip_blocks(fifo_cnt));
          remain_d    = clip_blocks(fifo_cnt);
        end
      end
      ST_REQ: state_d = ST_WRITE;
      ST_WRITE: begin
        if (D_W && (fifo_cnt != '0)) begin
          pop       = 1'b1;
          lines_d   = lines_q + 32'd1;
          cur_adr_d = next_line_adr(cur_adr_q);
          remain_d  = remain_q - CW'(1);
          if (remain_q == CW'(1)) state_d = ST_DRAIN_WAIT;
        end
      end
      ST_DRAIN_WAIT: begin
        if (!D_BUSY) state_d = ST_IDLE;
      end
      ST_FIN: begin
        state_d      = ST_IDLE;
        flush_pend_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (START) begin
      if (state_q == ST_IDLE) begin
        cur_adr_d    = BASE_ADR;
        lines_d      = 32'd0;
        lane_d       = '0;
        flush_pend_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    if (FLUSH) begin
      if (flush_pend_q) err_d = 1'b1;
      flush_pend_d = 1'b1;
    end

    if (IN_VALID && in_full)         err_d = 1'b1;
    if (D_W && (fifo_cnt == '0))     err_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      lane_q       <= '0;
      flush_pend_q <= 1'b0;
      cur_adr_q    <= 32'd0;
      lines_q      <= 32'd0;
      remain_q     <= '0;
      d_req_q      <= DRAM_REQ_NONE;
      d_initadr_q  <= 32'd0;
      d_blocks_q   <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      flush_pend_q <= flush_pend_d;
      cur_adr_q    <= cur_adr_d;
      lines_q      <= lines_d;
      remain_q     <= remain_d;
      d_req_q      <= d_req_d;
      d_initadr_q  <= d_initadr_d;
      d_blocks_q   <= d_blocks_d;
      err_q        <= err_d;
    end
    line_q <= line_d;
  end

  assign IN_FULL   = in_full;
  assign D_REQ     = d_req_q;
  assign D_INITADR = d_initadr_q;
  assign D_BLOCKS  = d_blocks_q;
  assign DONE      = (state_q == ST_FIN);
  assign ERR       = err_q;
  assign LINES     = lines_q;

endmodule

// File: tb/tb_sort_wb_packer.sv
// Scoreboard bench for sort_wb_packer: directed streams push expected
// requests and lines into queues; monitors pop and compare DUT output.
module tb_sort_wb_packer;
  import sort_wb_packer_pkg::*;

  logic             CLK = 1'b0;
  logic             RST, START, IN_VALID, FLUSH, D_BUSY, D_W;
  logic [31:0]      BASE_ADR, IN_KEY;
  logic             IN_FULL, DONE, ERR;
  logic [1:0]       D_REQ;
  logic [31:0]      D_INITADR, D_BLOCKS, LINES;
  logic [DRAMW-1:0] D_DIN;

  logic ctl_busy = 1'b0;
  logic stall    = 1'b0;
  assign D_BUSY = ctl_busy | stall;

  always #5 CLK = ~CLK;

  sort_wb_packer dut (
    .CLK(CLK), .RST(RST), .START(START), .BASE_ADR(BASE_ADR),
    .IN_VALID(IN_VALID), .IN_KEY(IN_KEY), .FLUSH(FLUSH), .IN_FULL(IN_FULL),
    .D_BUSY(D_BUSY), .D_W(D_W), .D_REQ(D_REQ), .D_INITADR(D_INITADR),
    .D_BLOCKS(D_BLOCKS), .D_DIN(D_DIN), .DONE(DONE), .ERR(ERR), .LINES(LINES)
  );

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int done_exp = 0;
  int lines_seen = 0;

  logic [DRAMW-1:0] exp_lines[$];
  logic [63:0]      exp_reqs[$];
  logic [63:0]      mon_req;
  logic [DRAMW-1:0] mon_line;
  logic [DRAMW-1:0] m_line;
  int               m_lane = 0;

  task automatic chk(input string name, input logic [DRAMW-1:0] got, input logic [DRAMW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [DRAMW-1:0] got);
    checks++;
    failures++;
    $display("FAIL %s got=%0h exp=none", name, got);
  endtask

  // ---------------- monitors ----------------
  always @(negedge CLK) begin
    #1;
    if (!RST) begin
      if (D_REQ != DRAM_REQ_NONE) begin
        if (exp_reqs.size() == 0) fail_now("unexpected_req", {D_INITADR, D_BLOCKS});
        else begin
          mon_req = exp_reqs.pop_front();
          chk("req_code", D_REQ, DRAM_REQ_WRITE);
          chk("req_initadr", D_INITADR, mon_req[63:32]);
          chk("req_blocks", D_BLOCKS, mon_req[31:0]);
        end
      end
      if (D_W) begin
        lines_seen++;
        if (exp_lines.size() == 0) fail_now("unexpected_line", D_DIN);
        else begin
          mon_line = exp_lines.pop_front();
          chk("line_data", D_DIN, mon_line);
        end
      end
      if (DONE) done_cnt++;
    end
  end

  // ---------------- controller model ----------------
  initial begin
    int n;
    D_W = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST && D_REQ == 2'd1) begin
        n = int'(D_BLOCKS);
        if (n > 16) n = 16;
        ctl_busy = 1'b1;
        for (int i = 0; i < n; i++) begin
          @(negedge CLK);
          if (RST) break;
          D_W = 1'b1;
          @(negedge CLK);
          D_W = 1'b0;
          if (RST) break;
        end
        D_W = 1'b0;
        ctl_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic model_key(input logic [31:0] k);
    m_line[32*m_lane +: 32] = k;
    m_lane++;
    if (m_lane == KPL) begin
      exp_lines.push_back(m_line);
      m_lane = 0;
    end
  endtask

  task automatic model_flush();
    if (m_lane != 0) begin
      for (int i = m_lane; i < KPL; i++) m_line[32*i +: 32] = 32'hFFFF_FFFF;
      exp_lines.push_back(m_line);
      m_lane = 0;
    end
  endtask

  task automatic send_key(input logic [31:0] k, input bit fl);
    int guard = 0;
    while (IN_FULL && guard < 3000) begin
      IN_VALID = 1'b0;
      @(negedge CLK);
      guard++;
    end
    if (guard >= 3000) fail_now("in_full_timeout", {31'd0, IN_FULL});
    IN_VALID = 1'b1;
    IN_KEY   = k;
    FLUSH    = fl;
    @(negedge CLK);
    IN_VALID = 1'b0;
    FLUSH    = 1'b0;
    model_key(k);
    if (fl) model_flush();
  endtask

  task automatic stream(input int first, input int n, input bit flush_last);
    for (int i = 0; i < n; i++) send_key(32'(first + i), flush_last && (i == n - 1));
  endtask

  task automatic pulse_flush();
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    model_flush();
  endtask

  task automatic do_start(input logic [31:0] base);
    START    = 1'b1;
    BASE_ADR = base;
    @(negedge CLK);
    START    = 1'b0;
    m_lane   = 0;
  endtask

  task automatic finish_phase(input string tag, input logic [31:0] exp_lines_cnt);
    int g = 0;
    done_exp++;
    while (done_cnt < done_exp && g < 4000) begin
      @(negedge CLK);
      g++;
    end
    repeat (2) @(negedge CLK);
    chk({tag, "_done"}, done_cnt, done_exp);
    chk({tag, "_lines"}, LINES, exp_lines_cnt);
    chk({tag, "_reqs_left"}, exp_reqs.size(), 0);
    chk({tag, "_lines_left"}, exp_lines.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int g;
    int ls0;
    RST = 1'b1; START = 1'b0; BASE_ADR = '0; IN_VALID = 1'b0; IN_KEY = '0; FLUSH = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_dreq", D_REQ, 0);
    chk("rst_initadr", D_INITADR, 0);
    chk("rst_blocks", D_BLOCKS, 0);
    chk("rst_in_full", IN_FULL, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_lines", LINES, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // 64 keys, one full burst at 0x100
    do_start(32'h100);
    exp_reqs.push_back({32'h100, 32'd4});
    stream(0, 64, 1'b0);
    pulse_flush();
    finish_phase("full_burst", 32'd4);
    chk("full_burst_err", ERR, 0);

    // 20 keys: one full line plus one padded line in a single request
    do_start(32'h400);
    exp_reqs.push_back({32'h400, 32'd2});
    stream(0, 20, 1'b0);
    pulse_flush();
    finish_phase("partial", 32'd2);

    // FLUSH together with the 16th key: no padding line
    do_start(32'h200);
    exp_reqs.push_back({32'h200, 32'd1});
    stream(100, 16, 1'b1);
    finish_phase("coincident", 32'd1);

    // address wrap: MEM_LAST-8, MEM_LAST, 0, 8 then next burst at 0x10
    do_start(32'h07FF_FFF0);
    exp_reqs.push_back({32'h07FF_FFF0, 32'd4});
    exp_reqs.push_back({32'h0000_0010, 32'd4});
    stream(0, 128, 1'b0);
    pulse_flush();
    finish_phase("wrap", 32'd8);

    // controller stalled: FIFO fills, input waits, nothing lost
    do_start(32'h1000);
    stall = 1'b1;
    exp_reqs.push_back({32'h1000, 32'd4});
    exp_reqs.push_back({32'h1020, 32'd4});
    exp_reqs.push_back({32'h1040, 32'd1});
    stream(0, 128, 1'b0);
    chk("stall_in_full", IN_FULL, 1);
    repeat (5) @(negedge CLK);
    chk("stall_in_full_held", IN_FULL, 1);
    chk("stall_no_req_lines", LINES, 0);
    stall = 1'b0;
    stream(128, 16, 1'b0);
    pulse_flush();
    finish_phase("stall", 32'd9);
    chk("stall_err", ERR, 0);

    // double FLUSH sets the sticky error
    FLUSH = 1'b1;
    repeat (2) @(negedge CLK);
    FLUSH = 1'b0;
    finish_phase("dbl_flush", 32'd9);
    chk("dbl_flush_err", ERR, 1);

    // reset in the middle of a write burst
    do_start(32'h800);
    exp_reqs.push_back({32'h800, 32'd4});
    ls0 = lines_seen;
    stream(0, 64, 1'b0);
    g = 0;
    while (lines_seen < ls0 + 1 && g < 2000) begin
      @(negedge CLK);
      g++;
    end
    chk("midrst_reached_write", 32'(lines_seen - ls0 >= 1), 1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("midrst_dreq", D_REQ, 0);
    chk("midrst_initadr", D_INITADR, 0);
    chk("midrst_blocks", D_BLOCKS, 0);
    chk("midrst_in_full", IN_FULL, 0);
    chk("midrst_done", DONE, 0);
    chk("midrst_err", ERR, 0);
    chk("midrst_lines", LINES, 0);
    exp_reqs.delete();
    exp_lines.delete();
    @(negedge CLK);
    do_start(32'h0);
    exp_reqs.push_back({32'h0, 32'd1});
    stream(500, 16, 1'b1);
    finish_phase("after_rst", 32'd1);
    chk("after_rst_err", ERR, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
